tcm_arbiter: RTL
================

# tcm_arbiter

Round-robin arbiter that shares one port of the dual-port TCM scratchpad between N_REQ bus masters, such as the CPU data-side and the Ethernet DMA engine. Each master issues a held request and receives a one-cycle ready pulse with read data. Accesses are serialized through a 4-state FSM, so the TCM sees only one access in flight. All TCM-side outputs are registered.

## Interface
- DATA_WIDTH, 32, TCM word width in bits; must be a multiple of 8
- N_ENTRIES, 1024, TCM depth in words
- ADDRW, $clog2(N_ENTRIES), word-address width
- N_REQ, 2, number of requesters; valid range 2..8
- clk_i  input  1  single clock for the block and the TCM port
- rst_i  input  1  reset, asynchronous, active-high
- req_i  input  N_REQ  request per master; held until that master's ready_o pulse
- we_i  input  N_REQ  write enable per master
- be_i  input  N_REQ*DATA_WIDTH/8  byte enables; master k occupies slice [k*DATA_WIDTH/8 +: DATA_WIDTH/8]
- addr_i  input  N_REQ*ADDRW  word addresses, packed the same way as be_i
- data_i  input  N_REQ*DATA_WIDTH  write data, packed the same way as be_i
- ready_o  output  N_REQ  one-hot, one-cycle completion pulse
- data_o  output  DATA_WIDTH  read data, shared by all masters; valid while any ready_o bit is high
- sram_en_o, sram_we_o  output  1  TCM port enable and write enable
- sram_be_o  output  DATA_WIDTH/8  TCM byte enables
- sram_addr_o  output  ADDRW  TCM address
- sram_data_o  output  DATA_WIDTH  TCM write data
- sram_data_i  input  DATA_WIDTH  TCM read data
- sram_ready_i  input  1  TCM ready; high the cycle after an enabled access

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE with req_i≠0:
  - pick winner w by round-robin, searching from index last+1 and wrapping modulo N_REQ;
  - register w, last←w, and w's we/be/addr/data into the sram_* outputs;
  - assert sram_en_o; go to ACCESS.
- IDLE with req_i=0: stay in IDLE; sram_en_o=0.
- ACCESS: sram_en_o is high for exactly this one cycle; go to WAIT.
- WAIT:
  - when sram_ready_i=1: data_o←sram_data_i, ready_o←one-hot(w), go to RESP;
  - otherwise hold in WAIT with sram_en_o=0.
- RESP: ready_o is high for this one cycle; clear it; go to IDLE.
- A ready pulse consumes the request. In the cycle after ready_o, the master either drops req_i or presents a new request; a held req_i is arbitrated again as a new access.
- Writes also pulse ready_o; data_o then carries the old word (read-before-write) and has no meaning.
- A req_i bit dropped before its grant is simply ignored. Dropping req_i after the grant has no effect: the access completes.
- Reset values:
  - state=IDLE, last=N_REQ-1 (so master 0 has first priority);
  - ready_o=0, data_o=0;
  - all sram_* outputs=0.
- Asynchronous reset in ACCESS may abort the write. A write latched by the TCM at that edge stays committed. No ready_o is issued for an aborted access.

## Timing
- Request seen in IDLE at cycle T:
  - sram_en_o=1 in cycle T+1;
  - TCM samples at the end of T+1;
  - sram_ready_i=1 in T+2;
  - ready_o and data_o valid in T+3;
  - IDLE again in T+4.
- Latency: 3 cycles from request to ready. Throughput: 1 access per 4 cycles.
- Simultaneous requests are resolved in one IDLE cycle. The winner is the nearest requester after last.
- Under continuous contention, each of N_REQ masters is served at least once every 4*N_REQ cycles.
- Every output is a flop; there are no combinational paths from any input to any output.

## Structure
- Shared package tcm_arb_pkg holds:
  - state encodings S_IDLE=2'd0, S_ACCESS=2'd1, S_WAIT=2'd2, S_RESP=2'd3;
  - the one-hot helper function.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req vector, last index.
  - Outputs: winner index, any-valid flag.
  - Reused by the future multi-port TCM controller.

## Test plan
- Single read: master 0 reads addr 0x010 holding 0xDEADBEEF. ready_o=2'b01 exactly at T+3; data_o=0xDEADBEEF; sram_en_o high for exactly one cycle.
- Byte-enable write then read: master 1 writes 0x11223344 with be=4'b0101 to a word holding 0xAABBCCDD, then reads it back. Read returns 0xAA22CC44.
- Contention: req_i=2'b11 held continuously for 16 cycles. Grants alternate 0,1,0,1; ready_o pulses every 4 cycles; no master waits more than 8 cycles.
- Slow TCM: sram_ready_i delayed 3 cycles. FSM holds in WAIT and ready_o arrives 3 cycles later. sram_en_o is not re-asserted.
- Reset in ACCESS: rst_i pulsed asynchronously mid-cycle. All outputs go to 0 immediately, state is IDLE, and no ready_o fires. After reset the next grant goes to master 0.
- Early drop: master 1 raises req_i then drops it before IDLE samples it. No TCM access occurs and ready_o stays 0.

Source files
------------

// File: rtl/tcm_arb_pkg.sv
// Shared definitions for the TCM arbiter: FSM state encoding and a one-hot helper.
package tcm_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/tcm_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request after last_i, wrapping around.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDXW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDXW-1:0]  last_i,
    output logic [IDXW-1:0]  win_o,
    output logic             valid_o
);

    int unsigned idx;

    always_comb begin
        win_o   = last_i;
        valid_o = 1'b0;
        idx     = 0;
        // Offset N_REQ is last_i itself, so it only wins when it is the sole requester.
        for (int off = 1; off <= N_REQ; off++) begin
            idx = unsigned'((int'(last_i) + off) % N_REQ);
            if (!valid_o && req_i[IDXW'(idx)]) begin
                win_o   = IDXW'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcm_arbiter.sv
// Round-robin arbiter serializing N_REQ masters onto a single TCM port; all outputs are flops.
module tcm_arbiter
    import tcm_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_ENTRIES  = 1024,
    parameter int ADDRW      = $clog2(N_ENTRIES),
    parameter int N_REQ      = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_REQ-1:0]                req_i,
    input  logic [N_REQ-1:0]                we_i,
    input  logic [N_REQ*DATA_WIDTH/8-1:0]   be_i,
    input  logic [N_REQ*ADDRW-1:0]          addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]     data_i,
    output logic [N_REQ-1:0]                ready_o,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic                            sram_en_o,
    output logic                            sram_we_o,
    output logic [DATA_WIDTH/8-1:0]         sram_be_o,
    output logic [ADDRW-1:0]                sram_addr_o,
    output logic [DATA_WIDTH-1:0]           sram_data_o,
    input  logic [DATA_WIDTH-1:0]           sram_data_i,
    input  logic                            sram_ready_i
);

    localparam int BEW  = DATA_WIDTH / 8;
    localparam int IDXW = $clog2(N_REQ);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_nreq
        $error("N_REQ must be in 2..8");
    end
    if (ADDRW < $clog2(N_ENTRIES)) begin : g_bad_addrw
        $error("ADDRW too narrow for N_ENTRIES");
    end

    logic [BEW-1:0]        be_arr   [N_REQ];
    logic [ADDRW-1:0]      addr_arr [N_REQ];
    logic [DATA_WIDTH-1:0] data_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign be_arr[gi]   = be_i[gi*BEW +: BEW];
        assign addr_arr[gi] = addr_i[gi*ADDRW +: ADDRW];
        assign data_arr[gi] = data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    state_t                state_q;
    logic [IDXW-1:0]       last_q;
    logic [N_REQ-1:0]      ready_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  sram_en_q;
    logic                  sram_we_q;
    logic [BEW-1:0]        sram_be_q;
    logic [ADDRW-1:0]      sram_addr_q;
    logic [DATA_WIDTH-1:0] sram_data_q;

    logic [IDXW-1:0]       pick_win;
    logic                  pick_valid;

    rr_pick #(.N_REQ(N_REQ), .IDXW(IDXW)) u_pick (
        .req_i   (req_i),
        .last_i  (last_q),
        .win_o   (pick_win),
        .valid_o (pick_valid)
    );

    // last_q doubles as the current winner: it is updated at grant and held until the response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            last_q      <= IDXW'(N_REQ - 1);
            ready_q     <= '0;
            data_q      <= '0;
            sram_en_q   <= 1'b0;
            sram_we_q   <= 1'b0;
            sram_be_q   <= '0;
            sram_addr_q <= '0;
            sram_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        last_q      <= pick_win;
                        sram_en_q   <= 1'b1;
                        sram_we_q   <= we_i[pick_win];
                        sram_be_q   <= be_arr[pick_win];
                        sram_addr_q <= addr_arr[pick_win];
                        sram_data_q <= data_arr[pick_win];
                        state_q     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    sram_en_q <= 1'b0;
                    sram_we_q <= 1'b0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (sram_ready_i) begin
                        data_q  <= sram_data_i;
                        ready_q <= N_REQ'(onehot(32'(last_q)));
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    ready_q <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign data_o      = data_q;
    assign sram_en_o   = sram_en_q;
    assign sram_we_o   = sram_we_q;
    assign sram_be_o   = sram_be_q;
    assign sram_addr_o = sram_addr_q;
    assign sram_data_o = sram_data_q;

endmodule
